// File: rtl/neuron_c_sequencer_if.sv
// Operand-in / result-out valid-ready streams of the neuron sequencer.
// slave is the sequencer's view, master the upstream/downstream side.
interface neuron_c_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;

  modport master (
    output in_valid, in_a, in_w, in_b, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_w, in_b, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/neuron_c_sequencer.sv
// Loads three (a,w,b) triples into the combinational neuron, waits SETTLE_CYCLES, captures n_y.
// Result valid SETTLE_CYCLES edges after the third accept; input stalls until the result is taken.
module neuron_c_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  neuron_c_sequencer_if.slave sif,
  output logic [WIDTH-1:0] n_a_1,
  output logic [WIDTH-1:0] n_a_2,
  output logic [WIDTH-1:0] n_a_3,
  output logic [WIDTH-1:0] n_w_1,
  output logic [WIDTH-1:0] n_w_2,
  output logic [WIDTH-1:0] n_w_3,
  output logic [WIDTH-1:0] n_b_1,
  output logic [WIDTH-1:0] n_b_2,
  output logic [WIDTH-1:0] n_b_3,
  input  logic [WIDTH-1:0] n_y,
  output logic             busy
);

  typedef enum logic [1:0] {LOAD, SETTLE, HOLD} state_t;

  state_t     state;
  logic [1:0] idx;
  logic [3:0] settle_cnt;

  // Gated by rst so nothing is advertised while reset is held.
  assign sif.in_ready = (state == LOAD) && !rst;
  assign busy         = (state != LOAD) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      idx           <= '0;
      settle_cnt    <= '0;
      sif.out_valid <= 1'b0;
      sif.out_y     <= '0;
      n_a_1 <= '0; n_a_2 <= '0; n_a_3 <= '0;
      n_w_1 <= '0; n_w_2 <= '0; n_w_3 <= '0;
      n_b_1 <= '0; n_b_2 <= '0; n_b_3 <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (sif.in_valid) begin
            case (idx)
              2'd0: begin n_a_1 <= sif.in_a; n_w_1 <= sif.in_w; n_b_1 <= sif.in_b; end
              2'd1: begin n_a_2 <= sif.in_a; n_w_2 <= sif.in_w; n_b_2 <= sif.in_b; end
              default: begin n_a_3 <= sif.in_a; n_w_3 <= sif.in_w; n_b_3 <= sif.in_b; end
            endcase
            if (idx == 2'd2) begin
              idx        <= '0;
              settle_cnt <= 4'(SETTLE_CYCLES);
              state      <= SETTLE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          // n_y is only trusted once operands have been stable for the full settle window.
          if (settle_cnt == 4'd1) begin
            sif.out_y     <= n_y;
            sif.out_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (sif.out_ready) begin
            sif.out_valid <= 1'b0;
            state         <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_c_sequencer.sv
// Directed table-driven bench for neuron_c_sequencer with SETTLE_CYCLES=1 and 4 instances.
module tb_neuron_c_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sel, in_valid, out_ready, ny_junk;
  logic [W-1:0] in_a, in_w, in_b;
  int checks = 0;
  int failures = 0;

  neuron_c_sequencer_if #(.WIDTH(W)) if0 ();
  neuron_c_sequencer_if #(.WIDTH(W)) if1 ();

  assign if0.in_valid  = in_valid & ~sel;
  assign if1.in_valid  = in_valid & sel;
  assign if0.out_ready = out_ready & ~sel;
  assign if1.out_ready = out_ready & sel;
  assign if0.in_a = in_a; assign if0.in_w = in_w; assign if0.in_b = in_b;
  assign if1.in_a = in_a; assign if1.in_w = in_w; assign if1.in_b = in_b;

  logic [W-1:0] na0 [3], nw0 [3], nb0 [3], na1 [3], nw1 [3], nb1 [3];
  logic [W-1:0] ny0, ny1;
  logic         busy0, busy1;

  // Neuron model: sum of a_k*w_k+b_k, truncated to W; junk whenever sampling must not happen.
  assign ny0 = ny_junk ? 32'hDEADBEEF :
               na0[0]*nw0[0] + nb0[0] + na0[1]*nw0[1] + nb0[1] + na0[2]*nw0[2] + nb0[2];
  assign ny1 = ny_junk ? 32'hDEADBEEF :
               na1[0]*nw1[0] + nb1[0] + na1[1]*nw1[1] + nb1[1] + na1[2]*nw1[2] + nb1[2];

  neuron_c_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .sif(if0),
    .n_a_1(na0[0]), .n_a_2(na0[1]), .n_a_3(na0[2]),
    .n_w_1(nw0[0]), .n_w_2(nw0[1]), .n_w_3(nw0[2]),
    .n_b_1(nb0[0]), .n_b_2(nb0[1]), .n_b_3(nb0[2]),
    .n_y(ny0), .busy(busy0)
  );

  neuron_c_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .sif(if1),
    .n_a_1(na1[0]), .n_a_2(na1[1]), .n_a_3(na1[2]),
    .n_w_1(nw1[0]), .n_w_2(nw1[1]), .n_w_3(nw1[2]),
    .n_b_1(nb1[0]), .n_b_2(nb1[1]), .n_b_3(nb1[2]),
    .n_y(ny1), .busy(busy1)
  );

  logic         cur_in_ready, cur_out_valid, cur_busy;
  logic [W-1:0] cur_out_y, cur_na1, cur_nw2, cur_nb3;
  always_comb begin
    cur_in_ready  = sel ? if1.in_ready  : if0.in_ready;
    cur_out_valid = sel ? if1.out_valid : if0.out_valid;
    cur_out_y     = sel ? if1.out_y     : if0.out_y;
    cur_busy      = sel ? busy1         : busy0;
    cur_na1       = sel ? na1[0]        : na0[0];
    cur_nw2       = sel ? nw1[1]        : nw0[1];
    cur_nb3       = sel ? nb1[2]        : nb0[2];
  end

  typedef struct {
    logic            sel;
    logic [2:0][W-1:0] a, w, b;
    int              gap;
    int              stall;
    logic            junk;
    logic [W-1:0]    exp_y;
  } vec_t;

  function automatic vec_t mk(input logic s,
                              input int a1, input int a2, input int a3,
                              input int w1, input int w2, input int w3,
                              input int b1, input int b2, input int b3,
                              input int gap, input int stall, input logic junk,
                              input logic [W-1:0] exp_y);
    vec_t v;
    v.sel = s;
    v.a[0] = a1; v.a[1] = a2; v.a[2] = a3;
    v.w[0] = w1; v.w[1] = w2; v.w[2] = w3;
    v.b[0] = b1; v.b[1] = b2; v.b[2] = b3;
    v.gap = gap; v.stall = stall; v.junk = junk; v.exp_y = exp_y;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] w, input logic [W-1:0] b);
    int t = 0;
    while (cur_in_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    check("in_ready_wait", {31'd0, cur_in_ready}, 32'd1);
    check("no_early_valid", {31'd0, cur_out_valid}, 32'd0);
    in_valid = 1'b1; in_a = a; in_w = w; in_b = b;
    step();
    in_valid = 1'b0; in_a = 32'h55555555; in_w = 32'h55555555; in_b = 32'h55555555;
  endtask

  task automatic run_vector(input vec_t v);
    int s;
    int lat;
    s = v.sel ? 4 : 1;
    sel = v.sel;
    ny_junk = v.junk;
    out_ready = (v.stall == 0);
    for (int k = 0; k < 3; k++) begin
      send(v.a[k], v.w[k], v.b[k]);
      if (k < 2) repeat (v.gap) step();
    end
    lat = 0;
    while (cur_out_valid !== 1'b1 && lat < 40) begin
      ny_junk = v.junk && (lat != s - 1);
      step();
      lat++;
    end
    ny_junk = v.junk;
    check("latency", lat, s);
    check("out_y", cur_out_y, v.exp_y);
    check("n_a_1", cur_na1, v.a[0]);
    check("n_w_2", cur_nw2, v.w[1]);
    check("n_b_3", cur_nb3, v.b[2]);
    check("busy_hold", {31'd0, cur_busy}, 32'd1);
    check("in_ready_hold", {31'd0, cur_in_ready}, 32'd0);
    for (int i = 0; i < v.stall; i++) begin
      in_valid = 1'b1; in_a = 32'h12345678; in_w = 32'h9ABCDEF0; in_b = 32'h0F0F0F0F;
      step();
      check("stall_valid", {31'd0, cur_out_valid}, 32'd1);
      check("stall_out_y", cur_out_y, v.exp_y);
      check("stall_in_ready", {31'd0, cur_in_ready}, 32'd0);
      check("stall_n_a_1", cur_na1, v.a[0]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", {31'd0, cur_out_valid}, 32'd0);
    check("in_ready_after", {31'd0, cur_in_ready}, 32'd1);
    check("busy_after", {31'd0, cur_busy}, 32'd0);
    check("out_y_keep", cur_out_y, v.exp_y);
  endtask

  vec_t tbl [7];

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ny_junk = 1'b0;
    in_a = '0; in_w = '0; in_b = '0;

    tbl[0] = mk(0, 1, 4, 7,  2, 5, 8,  3, 6, 9,  0, 0, 0, 32'd96);
    tbl[1] = mk(0, 1, 4, 7,  2, 5, 8,  3, 6, 9,  0, 5, 0, 32'd96);
    tbl[2] = mk(0, 1, 4, 7,  2, 5, 8,  3, 6, 9,  2, 0, 1, 32'd96);
    tbl[3] = mk(0, 32'h7FFFFFFF, 1, 0,  2, 1, 0,  5, 0, 0,  0, 0, 0, 32'd4);
    tbl[4] = mk(1, 1, 4, 7,  2, 5, 8,  3, 6, 9,  0, 0, 0, 32'd96);
    tbl[5] = mk(1, -1, 3, 0,  2, -4, 0,  0, 0, -5,  0, 0, 0, 32'hFFFFFFED);
    tbl[6] = mk(1, -3, 2, 100,  -3, -7, 0,  1, 0, 0,  1, 2, 1, 32'hFFFFFFFC);

    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_in_ready", {31'd0, if0.in_ready}, 32'd0);
      check("rst_busy", {31'd0, busy0}, 32'd0);
    end
    check("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    check("rst_out_y", if0.out_y, 32'd0);
    check("rst_out_valid_s4", {31'd0, if1.out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("rst_n_a", na0[k], 32'd0);
      check("rst_n_w", nw0[k], 32'd0);
      check("rst_n_b", nb0[k], 32'd0);
    end
    rst = 1'b0;
    #1;
    check("in_ready_post_rst", {31'd0, if0.in_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_vector(tbl[i]);

    // Partial vector followed by a reset pulse must leave no trace.
    sel = 1'b0; ny_junk = 1'b0; out_ready = 1'b1;
    send(32'd1, 32'd2, 32'd3);
    send(32'd4, 32'd5, 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    check("midrst_n_a_1", na0[0], 32'd0);
    check("midrst_n_w_2", nw0[1], 32'd0);
    check("midrst_in_ready", {31'd0, if0.in_ready}, 32'd1);
    run_vector(mk(0, -1, 3, 0,  2, -4, 0,  0, 0, -5,  0, 0, 0, 32'hFFFFFFED));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neuron_c_sequencer.md
Name: neuron_c_sequencer

Overview:
- Sequential front/back-end for the 3-input combinational neuron.
- Accepts (activation, weight, bias) operand triples one per handshake over a serial valid/ready stream, and registers them onto the neuron's nine parallel operand inputs.
- Waits a programmable settle time for the combinational multiply/add/activation path, then captures the neuron's y and presents it on a valid/ready result port.
- Sits between the layer's operand fetch logic and the next layer's input.

Parameters:
- WIDTH, 32, bit width of every operand and result (signed two's complement, passed through unmodified).
- SETTLE_CYCLES, 1, number of clock cycles the neuron operands are held stable before n_y is sampled; legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand triple on in_a/in_w/in_b is valid.
- in_ready  output  1  block accepts a triple this cycle.
- in_a  input  WIDTH  signed activation.
- in_w  input  WIDTH  signed weight.
- in_b  input  WIDTH  signed bias.
- out_valid  output  1  out_y holds a completed neuron result.
- out_ready  input  1  downstream accepts out_y this cycle.
- out_y  output  WIDTH  captured neuron result.
- n_a_1, n_a_2, n_a_3  output  WIDTH each  registered activations to neuron a_1..a_3.
- n_w_1, n_w_2, n_w_3  output  WIDTH each  registered weights to neuron w_1..w_3.
- n_b_1, n_b_2, n_b_3  output  WIDTH each  registered biases to neuron b_1..b_3.
- n_y  input  WIDTH  neuron output y.
- busy  output  1  high in SETTLE or HOLD.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=LOAD, index counter=0, settle counter=0.
  - out_valid=0, out_y=0, all n_* registers=0.
  - in_ready=0 and busy=0 while rst is high; in_ready=1 the first cycle after rst deasserts.
  - Reset mid-operation discards any partial vector or pending result with no output.
- FSM states: LOAD, SETTLE, HOLD.
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, in_a/in_w/in_b are written to n_a_k/n_w_k/n_b_k, where k=index+1; index increments.
  - Bubbles (in_valid=0) are allowed between triples and do not change state.
  - On the accept with index=2: index returns to 0, settle counter loads SETTLE_CYCLES, state goes to SETTLE.
- SETTLE:
  - in_ready=0; n_* registers are frozen.
  - Settle counter decrements each cycle.
  - In the cycle where the counter equals 1: at that edge, out_y is loaded with n_y, out_valid is set to 1, and state goes to HOLD.
  - n_y is sampled at no other time.
- HOLD:
  - out_valid=1; out_y and n_* are stable; in_ready=0.
  - in_valid is ignored: no data is stored.
  - On out_valid&out_ready: out_valid goes to 0 and state goes to LOAD; in_ready=1 the next cycle.
  - out_y keeps its last value until the next capture.
- Latency: if the third triple is accepted at edge E, out_valid rises after edge E+SETTLE_CYCLES.
  - With the default SETTLE_CYCLES=1: out_valid is high in the cycle following edge E+1.
- Throughput: one result per 3+SETTLE_CYCLES+1 cycles at best.
  - There is no overlap between loading the next vector and holding a result.
- No arithmetic in this block.
  - Operands and result are passed bit-exact; no saturation, rounding, or sign handling.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
Bench neuron model is n_y = a1*w1+b1 + a2*w2+b2 + a3*w3+b3, truncated to WIDTH.
1. Reset: hold rst 3 cycles -> out_valid=0, out_y=0, all n_*=0, busy=0, in_ready=0 during reset; in_ready=1 the first cycle after.
2. Basic: triples (1,2,3),(4,5,6),(7,8,9) back-to-back, out_ready=1 -> n_a_1=1, n_w_2=5, n_b_3=9; out_y=96; out_valid high exactly one cycle, after edge E+SETTLE_CYCLES.
3. Backpressure: repeat test 2 with out_ready=0 for 5 cycles and in_valid=1 with junk operands -> out_valid=1 and out_y=96 stable, in_ready=0, n_* unchanged; raise out_ready -> single handshake, then in_ready=1.
4. Bubbles / sampling: insert 2 idle cycles between triples; bench drives n_y=0xDEADBEEF except during the capture cycle -> out_y=96 only, never the junk value.
5. Reset mid-vector: accept 2 triples, pulse rst, then send (-1,2,0),(3,-4,0),(0,0,-5) -> no spurious out_valid; out_y=-19 (0xFFFFFFED).
6. Back-to-back vectors with SETTLE_CYCLES=4: vectors giving 96 then -19 -> results appear in order; each out_valid rises 4 edges after that vector's third accept.
